pipe_ctrl: RTL



---
 rtl/pipe_ctrl_if.sv | 35 +++
 rtl/pipe_ctrl.sv | 138 +++++++++++++
 2 files changed

// File: rtl/pipe_ctrl_if.sv
// Pipeline control bus: hazard/redirect requests from the stages toward
// pipe_ctrl, and the stall/flush commands plus counters it drives back.
interface pipe_ctrl_if #(
  parameter int STALL_CNT_W = 32,
  parameter int FLUSH_CNT_W = 16
);
  logic                   rdy;
  logic                   if_busy;
  logic                   if_done;
  logic                   id_load_use;
  logic                   mem_busy;
  logic                   ex_jump;
  logic [31:0]            ex_target;
  logic [2:0]             stall_command;
  logic [2:0]             jp;
  logic                   redirect_valid;
  logic [31:0]            redirect_pc;
  logic                   if_discard;
  logic [STALL_CNT_W-1:0] stall_cycles;
  logic [FLUSH_CNT_W-1:0] flush_count;

  // Pipeline stages: raise requests, consume commands.
  modport master (
    output rdy, if_busy, if_done, id_load_use, mem_busy, ex_jump, ex_target,
    input  stall_command, jp, redirect_valid, redirect_pc, if_discard,
           stall_cycles, flush_count
  );

  // Sequencer side.
  modport slave (
    input  rdy, if_busy, if_done, id_load_use, mem_busy, ex_jump, ex_target,
    output stall_command, jp, redirect_valid, redirect_pc, if_discard,
           stall_cycles, flush_count
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Central pipeline sequencer: arbitrates stall requests from IF/ID/MEM and
// redirects from EX, defers redirects while MEM is busy, discards the data
// of a fetch that was in flight when a redirect happened, and keeps
// stall/flush performance counters.
module pipe_ctrl #(
  parameter int STALL_CNT_W = 32,
  parameter int FLUSH_CNT_W = 16
) (
  input logic        clk,
  input logic        rst,
  pipe_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    HOLD_JUMP = 2'd1,
    DISCARD   = 2'd2
  } state_t;

  localparam logic [2:0] STALL_NULL  = 3'd0;
  localparam logic [2:0] STALL_FETCH = 3'd1;
  localparam logic [2:0] STALL_ISSUE = 3'd3;
  localparam logic [2:0] STALL_ALL   = 3'd4;
  localparam logic [2:0] JP_REDIRECT = 3'b101;

  state_t                 state, state_nxt;
  logic [31:0]            tgt, tgt_nxt;
  logic [STALL_CNT_W-1:0] stall_cnt;
  logic [FLUSH_CNT_W-1:0] flush_cnt;

  logic [2:0]  stall_c;
  logic [2:0]  jp_c;
  logic        rv_c;
  logic [31:0] rpc_c;
  logic        disc_c;

  // Saturating increment for the stall-cycle counter.
  function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
    return (&v) ? v : v + STALL_CNT_W'(1);
  endfunction

  // Where to go after a redirect: keep discarding if the fetch is still out.
  function automatic state_t after_redirect(input logic busy, input logic done);
    return (busy && !done) ? DISCARD : RUN;
  endfunction

  // Command decode and next-state selection from current state and requests.
  always_comb begin
    stall_c   = STALL_NULL;
    jp_c      = 3'b000;
    rv_c      = 1'b0;
    rpc_c     = 32'd0;
    disc_c    = 1'b0;
    state_nxt = state;
    tgt_nxt   = tgt;
    if (rst) begin
      stall_c = STALL_ALL;
    end else if (!bus.rdy) begin
      stall_c = STALL_ALL;
      disc_c  = (state == DISCARD);
    end else begin
      case (state)
        HOLD_JUMP: begin
          if (bus.mem_busy) begin
            stall_c = STALL_ALL;
          end else begin
            jp_c      = JP_REDIRECT;
            rv_c      = 1'b1;
            rpc_c     = tgt;
            state_nxt = after_redirect(bus.if_busy, bus.if_done);
          end
        end
        DISCARD: begin
          disc_c = 1'b1;
          if (bus.mem_busy) begin
            stall_c = STALL_ALL;
            if (bus.ex_jump) begin
              tgt_nxt   = bus.ex_target;
              state_nxt = HOLD_JUMP;
            end else if (bus.if_done) begin
              state_nxt = RUN;
            end
          end else if (bus.ex_jump) begin
            jp_c      = JP_REDIRECT;
            rv_c      = 1'b1;
            rpc_c     = bus.ex_target;
            state_nxt = after_redirect(bus.if_busy, bus.if_done);
          end else begin
            stall_c = STALL_FETCH;
            if (bus.if_done) state_nxt = RUN;
          end
        end
        default: begin
          if (bus.mem_busy) begin
            stall_c = STALL_ALL;
            if (bus.ex_jump) begin
              tgt_nxt   = bus.ex_target;
              state_nxt = HOLD_JUMP;
            end
          end else if (bus.ex_jump) begin
            jp_c      = JP_REDIRECT;
            rv_c      = 1'b1;
            rpc_c     = bus.ex_target;
            state_nxt = after_redirect(bus.if_busy, bus.if_done);
          end else if (bus.id_load_use) begin
            stall_c = STALL_ISSUE;
          end else if (bus.if_busy) begin
            stall_c = STALL_FETCH;
          end
        end
      endcase
    end
  end

  // State, latched redirect target and performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      tgt       <= 32'd0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (bus.rdy) begin
      state <= state_nxt;
      tgt   <= tgt_nxt;
      if (stall_c != STALL_NULL) stall_cnt <= sat_inc(stall_cnt);
      if (rv_c) flush_cnt <= flush_cnt + FLUSH_CNT_W'(1);
    end
  end

  assign bus.stall_command  = stall_c;
  assign bus.jp             = jp_c;
  assign bus.redirect_valid = rv_c;
  assign bus.redirect_pc    = rpc_c;
  assign bus.if_discard     = disc_c;
  assign bus.stall_cycles   = stall_cnt;
  assign bus.flush_count    = flush_cnt;

endmodule
